junction_sequencer: RTL and testbench

Per-junction cycle scheduler for the FF, BP and UP processor sets. Per training sample, it steps the junction's z-wide weight and activation memories through p*fo/z cycles in feedforward. When training, it then runs a combined backprop and update pass. It issues read addresses, processor-set enables and latency-aligned write-back strobes. It also handshakes with the layer above (start/done) and the layer below (next_ready stall).

---
 rtl/junction_sequencer_pkg.sv | 37 +++
 rtl/junction_sequencer_valid_delay.sv | 37 +++
 rtl/junction_sequencer.sv | 165 ++++++++++++++++
 tb/tb_junction_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/junction_sequencer_pkg.sv
// Shared types and helpers for the junction sequencer.
// Derived constants default to the reference junction geometry.
package junction_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FF,
    S_FF_DRAIN,
    S_BPUP,
    S_BPUP_DRAIN,
    S_DONE
  } state_t;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int cpc_of(input int p, input int fo, input int z);
    return (p * fo) / z;
  endfunction

  localparam int FO_DEF  = 2;
  localparam int P_DEF   = 16;
  localparam int Z_DEF   = 8;
  localparam int MEM_DEF = 1;
  localparam int LUT_DEF = 1;

  localparam int CPC    = cpc_of(P_DEF, FO_DEF, Z_DEF);
  localparam int FF_LAT = MEM_DEF + LUT_DEF;
  localparam int UP_LAT = MEM_DEF;

endpackage

// File: rtl/junction_sequencer_valid_delay.sv
// Depth-D shift register carrying a valid bit and its address.
// Keeps shifting every cycle; a stall shows up as a bubble.
module valid_delay
  import junction_sequencer_pkg::*;
#(
  parameter int D = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_addr,
  output logic         o_valid,
  output logic [W-1:0] o_addr
);

  logic [D-1:0]        r_v;
  logic [D-1:0][W-1:0] r_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      r_a <= '0;
    end else begin
      r_v[0] <= i_valid;
      r_a[0] <= i_addr;
      for (int i = 1; i < D; i++) begin
        r_v[i] <= r_v[i-1];
        r_a[i] <= r_a[i-1];
      end
    end
  end

  assign o_valid = r_v[D-1];
  assign o_addr  = r_a[D-1];

endmodule

// File: rtl/junction_sequencer.sv
// Per-junction FF / BP+UP cycle scheduler with
// latency-aligned write-back strobes.
module junction_sequencer
  import junction_sequencer_pkg::*;
#(
  parameter  int FO      = 2,
  parameter  int FI      = 4,
  parameter  int P       = 16,
  parameter  int N       = 8,
  parameter  int Z       = 8,
  parameter  int MEM_LAT = 1,
  parameter  int LUT_LAT = 1,
  localparam int CNT_W   = clog2_min1(cpc_of(P, FO, Z))
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             train,
  input  logic             next_ready,
  output logic             busy,
  output logic             done,
  output logic             ff_en,
  output logic             bp_en,
  output logic             up_en,
  output logic [CNT_W-1:0] rd_addr,
  output logic             act_wr_en,
  output logic [CNT_W-1:0] act_wr_addr,
  output logic             w_wr_en,
  output logic [CNT_W-1:0] w_wr_addr
);

  localparam int L_CPC    = cpc_of(P, FO, Z);
  localparam int L_FF_LAT = MEM_LAT + LUT_LAT;
  localparam int L_UP_LAT = MEM_LAT;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L_CPC - 1);
  localparam logic [3:0] FF_DLAST = 4'(L_FF_LAT - 1);
  localparam logic [3:0] UP_DLAST = 4'(L_UP_LAT - 1);

  // Both sides of the junction must see the same weight count.
  if (P * FO != N * FI) begin : g_bad_geom
    $error("junction_sequencer: P*FO must equal N*FI");
  end
  if ((P * FO) % Z != 0 || L_FF_LAT < 1 || L_UP_LAT < 1) begin : g_bad_cfg
    $error("junction_sequencer: bad Z or latency");
  end

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_drn, w_drn_nxt;
  logic             r_train, w_train_nxt;

  logic             w_busy, w_done, w_ff, w_bpup;
  logic [CNT_W-1:0] w_rd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_drn   <= '0;
      r_train <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drn   <= w_drn_nxt;
      r_train <= w_train_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drn_nxt   = r_drn;
    w_train_nxt = r_train;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_ff        = 1'b0;
    w_bpup      = 1'b0;
    w_rd        = '0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_train_nxt = train;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FF;
        end
      end
      S_FF: begin
        w_rd = r_cnt;
        w_ff = next_ready;
        if (next_ready) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_drn_nxt   = '0;
            w_state_nxt = S_FF_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_FF_DRAIN: begin
        if (r_drn == FF_DLAST) begin
          w_drn_nxt   = '0;
          w_state_nxt = r_train ? S_BPUP : S_DONE;
        end else begin
          w_drn_nxt = r_drn + 1'b1;
        end
      end
      S_BPUP: begin
        w_rd   = r_cnt;
        w_bpup = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_drn_nxt   = '0;
          w_state_nxt = S_BPUP_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BPUP_DRAIN: begin
        if (r_drn == UP_DLAST) begin
          w_drn_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_drn_nxt = r_drn + 1'b1;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy    = w_busy;
  assign done    = w_done;
  assign ff_en   = w_ff;
  assign bp_en   = w_bpup;
  assign up_en   = w_bpup;
  assign rd_addr = w_rd;

  valid_delay #(.D(L_FF_LAT), .W(CNT_W)) u_act_dly (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (w_ff),
    .i_addr  (w_rd),
    .o_valid (act_wr_en),
    .o_addr  (act_wr_addr)
  );

  valid_delay #(.D(L_UP_LAT), .W(CNT_W)) u_w_dly (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (w_bpup),
    .i_addr  (w_rd),
    .o_valid (w_wr_en),
    .o_addr  (w_wr_addr)
  );

endmodule

// File: tb/tb_junction_sequencer.sv
// Directed bench for junction_sequencer: default geometry
// (cpc=4) plus a cpc=1 instance.
module tb_junction_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic train = 1'b0;
  logic next_ready = 1'b1;

  logic       busy0, done0, ff0, bp0, up0, act0, w0;
  logic [1:0] rd0, aa0, wa0;
  logic       busy1, done1, ff1, bp1, up1, act1, w1;
  logic [0:0] rd1, aa1, wa1;

  int n_chk = 0;
  int n_err = 0;
  logic [12:0] ex [1:24];

  always #5 clk = ~clk;

  junction_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .train(train), .next_ready(next_ready),
    .busy(busy0), .done(done0), .ff_en(ff0),
    .bp_en(bp0), .up_en(up0), .rd_addr(rd0),
    .act_wr_en(act0), .act_wr_addr(aa0),
    .w_wr_en(w0), .w_wr_addr(wa0)
  );

  junction_sequencer #(.P(8), .FO(1), .Z(8), .N(2), .FI(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .train(train), .next_ready(next_ready),
    .busy(busy1), .done(done1), .ff_en(ff1),
    .bp_en(bp1), .up_en(up1), .rd_addr(rd1),
    .act_wr_en(act1), .act_wr_addr(aa1),
    .w_wr_en(w1), .w_wr_addr(wa1)
  );

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %013b exp %013b", tag, got, exp);
    end
  endtask

  // {busy,done,ff,bp,up,act,w,rd,aa,wa}; addrs masked by enables
  function automatic logic [12:0] mk(
    input logic b, input logic d, input logic f, input logic bu,
    input logic a, input logic w, input int rd, input int aa,
    input int wa);
    logic [1:0] r, x, y;
    r = rd[1:0];
    x = a ? aa[1:0] : 2'd0;
    y = w ? wa[1:0] : 2'd0;
    return {b, d, f, bu, bu, a, w, r, x, y};
  endfunction

  function automatic logic [12:0] obs(input bit sel1);
    if (sel1)
      return {busy1, done1, ff1, bp1, up1, act1, w1,
              1'b0, rd1, 1'b0, act1 ? aa1 : 1'b0,
              1'b0, w1 ? wa1 : 1'b0};
    return {busy0, done0, ff0, bp0, up0, act0, w0, rd0,
            act0 ? aa0 : 2'd0, w0 ? wa0 : 2'd0};
  endfunction

  task automatic set(input int k, input logic b, input logic d,
                     input logic f, input logic bu, input logic a,
                     input logic w, input int rd, input int aa,
                     input int wa);
    ex[k] = mk(b, d, f, bu, a, w, rd, aa, wa);
  endtask

  task automatic clr_ex();
    for (int i = 1; i <= 24; i++) ex[i] = '0;
  endtask

  // Start at edge t0, then check outputs seen at t1..tn.
  task automatic run(input string nm, input bit sel1,
                     input logic trn, input int n,
                     input logic [31:0] nrlow, input int stk,
                     input int rsk);
    @(posedge clk); #1;
    train = trn;
    next_ready = 1'b1;
    if (sel1) start1 = 1'b1;
    else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      next_ready = ~nrlow[k];
      reset_n = (k != rsk);
      if (sel1) start1 = (k == stk);
      else start0 = (k == stk);
      @(negedge clk);
      chk($sformatf("%s t%0d", nm, k), obs(sel1), ex[k]);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    next_ready = 1'b1;
  endtask

  task automatic settle(input string nm);
    int c;
    c = 0;
    while ((busy0 || busy1) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, " idle"}, {12'd0, busy0 | busy1}, 13'd0);
  endtask

  task automatic ff_part();
    set(1, 1,0,1,0,0,0, 0,0,0);
    set(2, 1,0,1,0,0,0, 1,0,0);
    set(3, 1,0,1,0,1,0, 2,0,0);
    set(4, 1,0,1,0,1,0, 3,1,0);
    set(5, 1,0,0,0,1,0, 0,2,0);
    set(6, 1,0,0,0,1,0, 0,3,0);
  endtask

  task automatic bpup_part();
    set(7,  1,0,0,1,0,0, 0,0,0);
    set(8,  1,0,0,1,0,1, 1,0,0);
    set(9,  1,0,0,1,0,1, 2,0,1);
    set(10, 1,0,0,1,0,1, 3,0,2);
    set(11, 1,0,0,0,0,1, 0,0,3);
    set(12, 1,1,0,0,0,0, 0,0,0);
  endtask

  initial begin
    // reset held with start high
    reset_n = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst0 c%0d", i), obs(1'b0), 13'd0);
      chk($sformatf("rst1 c%0d", i), obs(1'b1), 13'd0);
    end
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    reset_n = 1'b1;

    // inference only
    clr_ex();
    ff_part();
    set(7, 1,1,0,0,0,0, 0,0,0);
    run("s2", 1'b0, 1'b0, 8, 32'h0, 0, 0);
    settle("s2");

    // inference + training
    clr_ex();
    ff_part();
    bpup_part();
    run("s3", 1'b0, 1'b1, 13, 32'h0, 0, 0);
    settle("s3");

    // next_ready stall at t2..t3
    clr_ex();
    set(1, 1,0,1,0,0,0, 0,0,0);
    set(2, 1,0,0,0,0,0, 1,0,0);
    set(3, 1,0,0,0,1,0, 1,0,0);
    set(4, 1,0,1,0,0,0, 1,0,0);
    set(5, 1,0,1,0,0,0, 2,0,0);
    set(6, 1,0,1,0,1,0, 3,1,0);
    set(7, 1,0,0,0,1,0, 0,2,0);
    set(8, 1,0,0,0,1,0, 0,3,0);
    set(9, 1,1,0,0,0,0, 0,0,0);
    run("s4", 1'b0, 1'b0, 10, 32'h0000_000C, 0, 0);
    settle("s4");

    // start during BPUP must be ignored
    clr_ex();
    ff_part();
    bpup_part();
    run("s5a", 1'b0, 1'b1, 15, 32'h0, 8, 0);
    settle("s5a");

    // reset mid-BPUP, restart right after
    clr_ex();
    ff_part();
    bpup_part();
    set(10, 0,0,0,0,0,0, 0,0,0);
    set(11, 1,0,1,0,0,0, 0,0,0);
    set(12, 1,0,1,0,0,0, 1,0,0);
    run("s5b", 1'b0, 1'b1, 12, 32'h0, 10, 9);
    settle("s5b");

    // cpc = 1 geometry
    clr_ex();
    set(1, 1,0,1,0,0,0, 0,0,0);
    set(2, 1,0,0,0,0,0, 0,0,0);
    set(3, 1,0,0,0,1,0, 0,0,0);
    set(4, 1,0,0,1,0,0, 0,0,0);
    set(5, 1,0,0,0,0,1, 0,0,0);
    set(6, 1,1,0,0,0,0, 0,0,0);
    run("s6", 1'b1, 1'b1, 7, 32'h0, 0, 0);
    settle("s6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
